// File: rtl/modexp_ctrl_if.sv
// modexp_ctrl_if: request/result and divider handshake bundle for modexp_ctrl.
interface modexp_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int EXPW  = 16
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXPW-1:0]      exponent;
    logic [WIDTH-1:0]     modulus;
    logic [WIDTH-1:0]     result;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic                 div_start;
    logic [2*WIDTH-1:0]   div_x;
    logic [2*WIDTH-1:0]   div_y;
    logic [2*WIDTH-1:0]   div_r;
    logic                 div_done;
    logic                 div_dbz;

    modport slave (
        input  start, base, exponent, modulus, div_r, div_done, div_dbz,
        output result, busy, done, err, div_start, div_x, div_y
    );

    modport master (
        output start, base, exponent, modulus, div_r, div_done, div_dbz,
        input  result, busy, done, err, div_start, div_x, div_y
    );
endinterface

// File: rtl/modexp_ctrl.sv
// modexp_ctrl: left-to-right square-and-multiply sequencer computing base^exponent mod modulus,
// issuing one external divider operation per modular reduction.
module modexp_ctrl #(
    parameter int WIDTH = 16,
    parameter int EXPW  = 16
) (
    input logic          clk,
    input logic          rst_n,
    modexp_ctrl_if.slave bus
);
    localparam int DW = 2 * WIDTH;
    localparam int KW = (EXPW > 1) ? $clog2(EXPW) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
    typedef enum logic [1:0] {RED, SQ, MUL} op_t;

    state_t           r_state, w_state;
    op_t              r_op, w_op;
    logic [WIDTH-1:0] r_base, w_base;
    logic [EXPW-1:0]  r_exp, w_exp;
    logic [WIDTH-1:0] r_mod, w_mod;
    logic [KW-1:0]    r_k, w_k;
    logic [WIDTH-1:0] r_acc, w_acc;
    logic [WIDTH-1:0] r_b, w_b;
    logic [WIDTH-1:0] r_result, w_result;
    logic             r_busy, w_busy;
    logic             r_err, w_err;
    logic [WIDTH-1:0] w_rem;
    logic [DW-1:0]    w_acc_x, w_b_x;
    logic             w_unused;

    assign w_rem    = bus.div_r[WIDTH-1:0];
    assign w_unused = ^bus.div_r[DW-1:WIDTH];
    assign w_acc_x  = {{WIDTH{1'b0}}, r_acc};
    assign w_b_x    = {{WIDTH{1'b0}}, r_b};

    always_comb begin
        w_state  = r_state;
        w_op     = r_op;
        w_base   = r_base;
        w_exp    = r_exp;
        w_mod    = r_mod;
        w_k      = r_k;
        w_acc    = r_acc;
        w_b      = r_b;
        w_result = r_result;
        w_busy   = r_busy;
        w_err    = r_err;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_base = bus.base;
                    w_exp  = bus.exponent;
                    w_mod  = bus.modulus;
                    w_err  = 1'b0;
                    w_busy = 1'b1;
                    w_k    = KW'(EXPW - 1);
                    if (bus.modulus == '0) begin
                        w_state  = FIN;
                        w_err    = 1'b1;
                        w_result = '0;
                    end else begin
                        w_acc   = (bus.modulus == WIDTH'(1)) ? '0 : WIDTH'(1);
                        w_op    = RED;
                        w_state = ISSUE;
                    end
                end
            end
            ISSUE: w_state = WAIT;
            WAIT: begin
                if (bus.div_done) begin
                    if (bus.div_dbz) begin
                        w_err    = 1'b1;
                        w_result = '0;
                        w_state  = FIN;
                    end else begin
                        w_state = ISSUE;
                        if (r_op == RED) begin
                            w_b  = w_rem;
                            w_op = SQ;
                        end else begin
                            w_acc = w_rem;
                            // a set bit after its square needs a multiply before moving on
                            if (r_op == SQ && r_exp[r_k])
                                w_op = MUL;
                            else if (r_k == '0) begin
                                w_state  = FIN;
                                w_result = w_rem;
                            end else begin
                                w_k  = r_k - 1'b1;
                                w_op = SQ;
                            end
                        end
                    end
                end
            end
            FIN: begin
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= RED;
            r_base   <= '0;
            r_exp    <= '0;
            r_mod    <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_op     <= w_op;
            r_base   <= w_base;
            r_exp    <= w_exp;
            r_mod    <= w_mod;
            r_k      <= w_k;
            r_acc    <= w_acc;
            r_b      <= w_b;
            r_result <= w_result;
            r_busy   <= w_busy;
            r_err    <= w_err;
        end
    end

    // op, acc and b only change at the capture edge, so div_x is steady from ISSUE through WAIT
    assign bus.div_x     = (r_op == RED) ? {{WIDTH{1'b0}}, r_base} :
                           (r_op == SQ)  ? w_acc_x * w_acc_x : w_acc_x * w_b_x;
    assign bus.div_y     = {{WIDTH{1'b0}}, r_mod};
    assign bus.div_start = (r_state == ISSUE);
    assign bus.done      = (r_state == FIN);
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule
